// File: rtl/act_pwl_pipe.sv
// act_pwl_pipe: three-stage piecewise-linear tanh / sigmoid activation.
// The data is two's complement fixed point with FRAC fractional bits, so ONE = 1 << FRAC.
// Parameters are only meaningful when WIDTH - FRAC >= 3. That headroom lets 2*ONE and ONE + y fit.
// Optional feature (macro ACT_DERIV_EN): when defined, the block also registers the activation
// derivative o_deriv alongside o_data in the last stage.
// The pipeline has a single stall condition: every stage moves together when the output register
// is empty or being drained (adv).
module act_pwl_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_mode,
  input  logic                    i_valid,
  output logic                    i_ready,
  output logic signed [WIDTH-1:0] o_data,
  output logic                    o_valid,
  input  logic                    o_ready
`ifdef ACT_DERIV_EN
  ,
  output logic signed [WIDTH-1:0] o_deriv
`endif
);

  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) <<< FRAC;
  localparam logic signed [WIDTH-1:0] HALF    = ONE >>> 1;
  localparam logic signed [WIDTH-1:0] QUARTER = ONE >>> 2;
  localparam logic signed [WIDTH-1:0] TWO     = ONE <<< 1;
  localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // |x|. The most negative code has no positive twin, so it saturates to the largest positive value.
  function automatic logic signed [WIDTH-1:0] sat_abs(input logic signed [WIDTH-1:0] x);
    if (x == MIN_NEG) return MAX_POS;
    else if (x[WIDTH-1]) return -x;
    else return x;
  endfunction

  // Four-segment magnitude curve on a non-negative input. The shifts truncate toward zero.
  function automatic logic signed [WIDTH-1:0] pwl_mag(input logic signed [WIDTH-1:0] b);
    if (b < HALF) return b;
    else if (b < ONE) return (b >>> 1) + QUARTER;
    else if (b < TWO) return (b >>> 2) + HALF;
    else return ONE;
  endfunction

  // Apply the sign. For sigmoid, also fold the odd curve into the range [0, ONE].
  function automatic logic signed [WIDTH-1:0] act_out(input logic signed [WIDTH-1:0] m,
                                                      input logic neg, input logic sig);
    logic signed [WIDTH-1:0] s;
    s = neg ? -m : m;
    if (sig) return (s + ONE) >>> 1;
    return s;
  endfunction

`ifdef ACT_DERIV_EN
  // The derivative is formed from y itself.
  // tanh: ONE - y^2. sigmoid: y*(ONE - y). The full-width product is truncated back to WIDTH bits.
  function automatic logic signed [WIDTH-1:0] act_deriv(input logic signed [WIDTH-1:0] y,
                                                        input logic sig);
    logic signed [WIDTH-1:0]   d;
    logic signed [2*WIDTH-1:0] ye;
    logic signed [2*WIDTH-1:0] fe;
    d  = ONE - y;
    ye = {{WIDTH{y[WIDTH-1]}}, y};
    fe = {{WIDTH{d[WIDTH-1]}}, d};
    if (sig) return WIDTH'((ye * fe) >>> FRAC);
    return ONE - WIDTH'((ye * ye) >>> FRAC);
  endfunction
`endif

  logic                    adv;
  logic signed [WIDTH-1:0] a_p0;
  logic                    neg_p0;
  logic                    sig_p0;
  logic                    vld_p0;
  logic signed [WIDTH-1:0] m_p1;
  logic                    neg_p1;
  logic                    sig_p1;
  logic                    vld_p1;
  logic signed [WIDTH-1:0] y_p1;
  logic signed [WIDTH-1:0] y_p2;
  logic                    vld_p2;

  assign adv     = !vld_p2 || o_ready;
  assign i_ready = adv;
  assign o_valid = vld_p2;
  assign o_data  = y_p2;
  assign y_p1    = act_out(m_p1, neg_p1, sig_p1);

  // Valid bits for all three stages. Reset drops every in-flight sample and takes priority over adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= i_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: magnitude, sign and mode of the accepted operand
  // Stage-1 data register.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p0   <= sat_abs(i_data);
      neg_p0 <= i_data[WIDTH-1];
      sig_p0 <= i_mode;
    end
  end

  // ---- stage 2: PWL magnitude. Sigmoid evaluates the curve at |x|/2.
  // Stage-2 data register.
  always_ff @(posedge clk) begin
    if (adv) begin
      m_p1   <= pwl_mag(sig_p0 ? (a_p0 >>> 1) : a_p0);
      neg_p1 <= neg_p0;
      sig_p1 <= sig_p0;
    end
  end

  // ---- stage 3: signed result. It is cleared on reset so the output reads zero afterwards.
  // Output data register. It holds its value while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) y_p2 <= '0;
    else if (adv) y_p2 <= y_p1;
  end

`ifdef ACT_DERIV_EN
  logic signed [WIDTH-1:0] deriv_p2;
  assign o_deriv = deriv_p2;

  // Derivative register. It is loaded alongside y_p2 from the same stage-3 result.
  always_ff @(posedge clk) begin
    if (rst) deriv_p2 <= '0;
    else if (adv) deriv_p2 <= act_deriv(y_p1, sig_p1);
  end
`endif

endmodule
